// File: rtl/irq_controller.sv
// irq_controller: vectored interrupt controller with pending/enable/edge registers and claim/complete handshake.
// Define IRQC_SYNC_EN to pass irq_src through a 2-flop synchronizer before edge detection.
module irq_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reg_en,
  input  logic               reg_we,
  input  logic [3:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq,
  output logic [3:0]         cpu_irq_id
);
  typedef enum logic [1:0] {IDLE, ASSERT, IN_SERVICE} state_t;
  state_t state;
  logic global_en, rd, wr, claim, unused_wdata;
  logic [NUM_SRC-1:0] enable, edge_sel, pending, src, src_q, set, clr, masked, claim_oh;
  logic [3:0] sel, active_id;
  logic [31:0] rd_val;
`ifdef IRQC_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  assign src = sync2;
`else
  assign src = irq_src;
`endif
  assign rd = reg_en && !reg_we;
  assign wr = reg_en && reg_we;
  assign masked = pending & enable;
  assign claim = rd && reg_addr == 4'd4 && state == ASSERT && |masked;
  assign set = src & ~(edge_sel & src_q);
  assign clr = (wr && reg_addr == 4'd3 ? reg_wdata[NUM_SRC-1:0] : '0) | claim_oh;
  assign unused_wdata = ^reg_wdata;
  // lowest index wins, so scan from the top down
  always_comb begin
    sel = '0;
    claim_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (masked[i]) sel = 4'(i);
    for (int i = 0; i < NUM_SRC; i++)
      claim_oh[i] = claim && sel == 4'(i);
  end
  always_comb begin
    rd_val = '0;
    case (reg_addr)
      4'd0: rd_val = {31'b0, global_en};
      4'd1: rd_val = 32'(enable);
      4'd2: rd_val = 32'(edge_sel);
      4'd3: rd_val = 32'(pending);
      4'd4: rd_val = claim ? {1'b1, 27'b0, sel} : '0;
      4'd5: rd_val = {state == IN_SERVICE, 27'b0, active_id};
      default: rd_val = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      global_en <= 1'b0;
      enable <= '0;
      edge_sel <= '0;
      pending <= '0;
      src_q <= '0;
      active_id <= '0;
      reg_rdata <= '0;
      cpu_irq <= 1'b0;
      cpu_irq_id <= '0;
    end else begin
      src_q <= src;
      pending <= (pending & ~clr) | set;
      cpu_irq_id <= sel;
      if (rd) reg_rdata <= rd_val;
      if (wr && reg_addr == 4'd0) global_en <= reg_wdata[0];
      if (wr && reg_addr == 4'd1) enable <= reg_wdata[NUM_SRC-1:0];
      if (wr && reg_addr == 4'd2) edge_sel <= reg_wdata[NUM_SRC-1:0];
      case (state)
        IDLE:
          if (global_en && |masked) begin
            state <= ASSERT;
            cpu_irq <= 1'b1;
          end
        ASSERT:
          if (claim) begin
            state <= IN_SERVICE;
            active_id <= sel;
            cpu_irq <= 1'b0;
          end else if (!global_en || ~|masked) begin
            state <= IDLE;
            cpu_irq <= 1'b0;
          end
        IN_SERVICE:
          if (wr && reg_addr == 4'd4 && reg_wdata[3:0] == active_id) begin
            state <= IDLE;
            active_id <= '0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller (default build, NUM_SRC = 8).
module tb_irq_controller;
  logic clk = 1'b0, rst_n = 1'b0, reg_en = 1'b0, reg_we = 1'b0, cpu_irq;
  logic [3:0] reg_addr = '0, cpu_irq_id;
  logic [31:0] reg_wdata = '0, reg_rdata, d;
  logic [7:0] irq_src = '0;
  int total = 0, bad = 0;
  irq_controller #(.NUM_SRC(8)) dut (
    .clk(clk), .rst_n(rst_n), .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq_src(irq_src),
    .cpu_irq(cpu_irq), .cpu_irq_id(cpu_irq_id)
  );
  always #5 clk = ~clk;
  task automatic do_reset();
    @(negedge clk);
    irq_src = '0;
    reg_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wr_reg(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    reg_en = 1'b1;
    reg_we = 1'b1;
    reg_addr = a;
    reg_wdata = v;
    @(negedge clk);
    reg_en = 1'b0;
    reg_we = 1'b0;
  endtask
  task automatic rd_reg(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    reg_en = 1'b1;
    reg_we = 1'b0;
    reg_addr = a;
    @(negedge clk);
    reg_en = 1'b0;
    v = reg_rdata;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL reset_cpu_irq got=%0d exp=0", cpu_irq); end
    total++; if (cpu_irq_id !== 4'd0) begin bad++; $display("FAIL reset_cpu_irq_id got=%0d exp=0", cpu_irq_id); end
    total++; if (reg_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", reg_rdata); end
    for (int a = 0; a < 8; a++) begin
      rd_reg(4'(a), d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, d); end
    end
  endtask
  task automatic test_level();
    do_reset();
    wr_reg(4'd0, 32'd1);
    wr_reg(4'd1, 32'h03);
    @(negedge clk);
    irq_src = 8'h02;
    rd_reg(4'd3, d);
    total++; if (d !== 32'h02) begin bad++; $display("FAIL level_pending got=%h exp=00000002", d); end
    total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL level_irq_rise got=%0d exp=1", cpu_irq); end
    total++; if (cpu_irq_id !== 4'd1) begin bad++; $display("FAIL level_irq_id got=%0d exp=1", cpu_irq_id); end
    rd_reg(4'd4, d);
    total++; if (d !== 32'h80000001) begin bad++; $display("FAIL level_claim got=%h exp=80000001", d); end
    total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL level_irq_fall got=%0d exp=0", cpu_irq); end
    rd_reg(4'd4, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL level_claim_in_service got=%h exp=0", d); end
    wr_reg(4'd4, 32'd1);
    total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL level_after_complete got=%0d exp=0", cpu_irq); end
    @(negedge clk);
    total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL level_reassert got=%0d exp=1", cpu_irq); end
    irq_src = '0;
  endtask
  task automatic test_priority();
    do_reset();
    wr_reg(4'd0, 32'd1);
    wr_reg(4'd1, 32'h09);
    @(negedge clk);
    irq_src = 8'h09;
    @(negedge clk);
    irq_src = '0;
    rd_reg(4'd4, d);
    total++; if (d !== 32'h80000000) begin bad++; $display("FAIL prio_first_claim got=%h exp=80000000", d); end
    wr_reg(4'd4, 32'd0);
    rd_reg(4'd4, d);
    total++; if (d !== 32'h80000003) begin bad++; $display("FAIL prio_second_claim got=%h exp=80000003", d); end
    total++; if (cpu_irq_id !== 4'd3) begin bad++; $display("FAIL prio_irq_id got=%0d exp=3", cpu_irq_id); end
  endtask
  task automatic test_edge();
    do_reset();
    wr_reg(4'd0, 32'd1);
    wr_reg(4'd1, 32'h04);
    wr_reg(4'd2, 32'h04);
    @(negedge clk);
    irq_src = 8'h04;
    @(negedge clk);
    irq_src = '0;
    rd_reg(4'd3, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL edge_pulse_pending got=%h exp=00000004", d); end
    rd_reg(4'd4, d);
    total++; if (d !== 32'h80000002) begin bad++; $display("FAIL edge_pulse_claim got=%h exp=80000002", d); end
    wr_reg(4'd4, 32'd2);
    @(negedge clk);
    irq_src = 8'h04;
    rd_reg(4'd3, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL edge_hold_pending got=%h exp=00000004", d); end
    rd_reg(4'd4, d);
    total++; if (d !== 32'h80000002) begin bad++; $display("FAIL edge_hold_claim got=%h exp=80000002", d); end
    rd_reg(4'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_no_reset got=%h exp=0", d); end
    wr_reg(4'd4, 32'd2);
    repeat (4) @(negedge clk);
    total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL edge_stays_low got=%0d exp=0", cpu_irq); end
    irq_src = '0;
  endtask
  task automatic test_mismatch();
    do_reset();
    wr_reg(4'd0, 32'd1);
    wr_reg(4'd1, 32'h04);
    @(negedge clk);
    irq_src = 8'h04;
    @(negedge clk);
    irq_src = '0;
    rd_reg(4'd4, d);
    total++; if (d !== 32'h80000002) begin bad++; $display("FAIL mism_claim got=%h exp=80000002", d); end
    wr_reg(4'd4, 32'd5);
    rd_reg(4'd5, d);
    total++; if (d !== 32'h80000002) begin bad++; $display("FAIL mism_active got=%h exp=80000002", d); end
    wr_reg(4'd4, 32'd2);
    rd_reg(4'd5, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mism_complete got=%h exp=0", d); end
  endtask
  task automatic test_masked();
    do_reset();
    wr_reg(4'd0, 32'd1);
    @(negedge clk);
    irq_src = 8'h10;
    @(negedge clk);
    irq_src = '0;
    rd_reg(4'd3, d);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL masked_pending got=%h exp=00000010", d); end
    repeat (2) @(negedge clk);
    total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL masked_no_irq got=%0d exp=0", cpu_irq); end
    wr_reg(4'd2, 32'h10);
    @(negedge clk);
    reg_en = 1'b1;
    reg_we = 1'b1;
    reg_addr = 4'd3;
    reg_wdata = 32'h10;
    irq_src = 8'h10;
    @(negedge clk);
    reg_en = 1'b0;
    reg_we = 1'b0;
    rd_reg(4'd3, d);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL w1c_set_wins got=%h exp=00000010", d); end
    wr_reg(4'd3, 32'h10);
    rd_reg(4'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h exp=0", d); end
    irq_src = '0;
  endtask
  task automatic test_reset_in_service();
    do_reset();
    wr_reg(4'd0, 32'd1);
    wr_reg(4'd1, 32'h06);
    @(negedge clk);
    irq_src = 8'h06;
    @(negedge clk);
    rd_reg(4'd4, d);
    total++; if (d !== 32'h80000001) begin bad++; $display("FAIL rst_claim got=%h exp=80000001", d); end
    total++; if (cpu_irq_id !== 4'd1) begin bad++; $display("FAIL rst_pre_id got=%0d exp=1", cpu_irq_id); end
    rst_n = 1'b0;
    #1;
    total++; if (reg_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", reg_rdata); end
    total++; if (cpu_irq_id !== 4'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", cpu_irq_id); end
    total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%0d exp=0", cpu_irq); end
    irq_src = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_reg(4'd5, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_active got=%h exp=0", d); end
  endtask
  initial begin
    test_reset();
    test_level();
    test_priority();
    test_edge();
    test_mismatch();
    test_masked();
    test_reset_in_service();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
